// File: rtl/alu_mdu_pkg.sv
// Shared encodings for the EX-stage ALU and the iterative multiply/divide unit.
package alu_mdu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b?000;
  localparam logic [3:0] ALU_SUB = 4'b?100;
  localparam logic [3:0] ALU_AND = 4'b?001;
  localparam logic [3:0] ALU_OR  = 4'b?101;
  localparam logic [3:0] ALU_XOR = 4'b?010;
  localparam logic [3:0] ALU_LUI = 4'b?110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/mdu_iter.sv
// Radix-2 iterative multiply/divide unit with architectural HI/LO registers.
module mdu_iter
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  output logic             md_busy,
  output logic             md_done,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHW = $clog2(WIDTH);

  md_state_e        state;
  logic [SHW:0]     count;
  logic             div_l;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] a_l;
  logic [WIDTH-1:0] b_l;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH:0]     rem_nx;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   hi_res;
  logic [WIDTH-1:0]   lo_res;
  logic               is_signed;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  assign md_busy   = (state != S_IDLE);
  assign is_signed = ~md_op[0];

  always_comb begin
    mul_sum = {1'b0, acc} + (q[0] ? {1'b0, m_r} : '0);
    rem_sh  = {acc, q[WIDTH-1]};
    rem_ge  = (rem_sh >= {1'b0, m_r});
    rem_nx  = rem_ge ? (rem_sh - {1'b0, m_r}) : rem_sh;
  end

  // Result fix-up: undo operand magnitudes; divide-by-zero returns all-ones / dividend.
  always_comb begin
    prod_fix = neg_q ? -{acc, q} : {acc, q};
    hi_res   = prod_fix[2*WIDTH-1:WIDTH];
    lo_res   = prod_fix[WIDTH-1:0];
    if (div_l) begin
      if (b_l == '0) begin
        hi_res = a_l;
        lo_res = '1;
      end else begin
        hi_res = neg_r ? -acc : acc;
        lo_res = neg_q ? -q : q;
      end
    end
  end

  // Iteration datapath: multiply keeps {acc,q} as the shifting product,
  // divide keeps acc as partial remainder and q as dividend/quotient.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && md_start) begin
      a_l   <= a;
      b_l   <= b;
      div_l <= md_op[1];
      neg_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= is_signed && a[WIDTH-1];
      m_r   <= md_op[1] ? mag(b, is_signed) : mag(a, is_signed);
      q     <= md_op[1] ? mag(a, is_signed) : mag(b, is_signed);
      acc   <= '0;
    end else if (state == S_RUN) begin
      if (div_l) begin
        acc <= rem_nx[WIDTH-1:0];
        q   <= {q[WIDTH-2:0], rem_ge};
      end else begin
        acc <= mul_sum[WIDTH:1];
        q   <= {mul_sum[0], q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= S_IDLE;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      md_done <= 1'b0;
    end else begin
      md_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hi_we) hi <= a;
          if (lo_we) lo <= a;
          if (md_start) begin
            state <= S_RUN;
            count <= '0;
          end
        end
        S_RUN: begin
          count <= count + 1'b1;
          if (count == (SHW+1)'(WIDTH-1)) state <= S_FIX;
        end
        S_FIX: begin
          hi      <= hi_res;
          lo      <= lo_res;
          md_done <= 1'b1;
          count   <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU (combinational) plus iterative MD unit with HI/LO.
// Optional macro ALU_MDU_OVF_EN adds the signed ADD/SUB overflow output ovf.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluc,
  output logic [WIDTH-1:0] s,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  output logic             md_busy,
  output logic             md_done,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef ALU_MDU_OVF_EN
  ,output logic            ovf
`endif
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]          sa;
  logic signed [WIDTH-1:0] b_s;

  assign sa  = a[SHW-1:0];
  assign b_s = b;

  always_comb begin
    s = '0;
    casez (aluc)
      4'b?000: s = a + b;
      4'b?100: s = a - b;
      4'b?001: s = a & b;
      4'b?101: s = a | b;
      4'b?010: s = a ^ b;
      4'b?110: s = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      4'b0011: s = b << sa;
      4'b0111: s = b >> sa;
      4'b1111: s = b_s >>> sa;
      default: s = '0;
    endcase
  end

`ifdef ALU_MDU_OVF_EN
  always_comb begin
    ovf = 1'b0;
    if (aluc[1:0] == 2'b00)
      ovf = (aluc[2] ? (a[WIDTH-1] != b[WIDTH-1]) : (a[WIDTH-1] == b[WIDTH-1]))
            && (s[WIDTH-1] != a[WIDTH-1]);
  end
`endif

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk      (clk),
    .clrn     (clrn),
    .a        (a),
    .b        (b),
    .md_start (md_start),
    .md_op    (md_op),
    .md_busy  (md_busy),
    .md_done  (md_done),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .hi       (hi),
    .lo       (lo)
  );

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu at WIDTH=32: ALU vector table, MD corner sequences, random ops vs model.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] a, b, s, hi, lo;
  logic [3:0]  aluc;
  logic        md_start, md_busy, md_done, hi_we, lo_we;
  logic [1:0]  md_op;
`ifdef ALU_MDU_OVF_EN
  logic        ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .clrn(clrn), .a(a), .b(b), .aluc(aluc), .s(s),
    .md_start(md_start), .md_op(md_op), .md_busy(md_busy), .md_done(md_done),
    .hi_we(hi_we), .lo_we(lo_we), .hi(hi), .lo(lo)
`ifdef ALU_MDU_OVF_EN
    , .ovf(ovf)
`endif
  );

  typedef struct {
    string       name;
    logic [3:0]  aluc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    int unsigned sh;
    sh = x % 32;
    case (op[2:0])
      3'b000: return x + y;
      3'b100: return x - y;
      3'b001: return x & y;
      3'b101: return x | y;
      3'b010: return x ^ y;
      3'b110: return (y % 65536) * 65536;
      3'b011: return op[3] ? 32'd0 : y << sh;
      3'b111: return op[3] ? 32'(int'(y) >>> sh) : y >> sh;
      default: return 32'd0;
    endcase
  endfunction

  task automatic md_model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] rh, output logic [31:0] rl);
    longint      sx, sy;
    logic [63:0] p, qq, rr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      2'b00: p = sx * sy;
      2'b01: p = {32'd0, x} * {32'd0, y};
      default: p = '0;
    endcase
    rh = p[63:32];
    rl = p[31:0];
    if (op[1]) begin
      if (y == 0) begin
        rh = x;
        rl = 32'hFFFF_FFFF;
      end else if (op == 2'b10) begin
        qq = sx / sy;
        rr = sx % sy;
        rh = rr[31:0];
        rl = qq[31:0];
      end else begin
        rh = x % y;
        rl = x / y;
      end
    end
  endtask

  task automatic wait_done(inout int k);
    while (!md_done && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  // Called 1 time unit after a rising edge with the unit idle.
  task automatic do_md(input logic [1:0] op, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] eh, input logic [31:0] el, input string nm);
    int k, busy_n;
    a = va; b = vb; md_op = op; md_start = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0;
    a = $urandom; b = $urandom;
    k = 0; busy_n = 0;
    while (k <= 60) begin
      if (md_busy) busy_n++;
      if (md_done) break;
      @(posedge clk); #1;
      k++;
    end
    chk({nm, "_latency"}, k, 33);
    chk({nm, "_busy_cycles"}, busy_n, 33);
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, {31'd0, md_done}, 0);
    chk({nm, "_hi_hold"}, hi, eh);
  endtask

  initial begin
    logic [31:0] eh, el, ra, rb;
    logic [3:0]  rop;
    logic [1:0]  mop;
    int k;

    tbl[0]  = '{"sra",      4'b1111, 32'd4,         32'h8000_0000, 32'hF800_0000};
    tbl[1]  = '{"lui",      4'b0110, 32'd0,         32'h0000_1234, 32'h1234_0000};
    tbl[2]  = '{"undef",    4'b1011, 32'd5,         32'd7,         32'h0};
    tbl[3]  = '{"add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'd1,         32'h0};
    tbl[4]  = '{"sub",      4'b0100, 32'd0,         32'd1,         32'hFFFF_FFFF};
    tbl[5]  = '{"and",      4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    tbl[6]  = '{"or",       4'b0101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0};
    tbl[7]  = '{"xor",      4'b1010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
    tbl[8]  = '{"sll",      4'b0011, 32'd31,        32'd1,         32'h8000_0000};
    tbl[9]  = '{"srl",      4'b0111, 32'd4,         32'h8000_0000, 32'h0800_0000};
    tbl[10] = '{"lui_x",    4'b1110, 32'd0,         32'hFFFF_5678, 32'h5678_0000};
    tbl[11] = '{"add_x",    4'b1000, 32'd3,         32'd4,         32'd7};
    tbl[12] = '{"sra_mask", 4'b1111, 32'h20,        32'h8000_0000, 32'h8000_0000};

    clrn = 1'b0; a = '0; b = '0; aluc = '0;
    md_start = 1'b0; md_op = '0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", {31'd0, md_busy}, 0);
    chk("rst_done", {31'd0, md_done}, 0);
    #2 clrn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      aluc = tbl[i].aluc; a = tbl[i].a; b = tbl[i].b;
      #1;
      chk({"alu_", tbl[i].name}, s, tbl[i].exp);
    end
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom); ra = $urandom; rb = $urandom;
      aluc = rop; a = ra; b = rb;
      #1;
      chk($sformatf("alu_rand_%0d_op%b", i, rop), s, alu_model(rop, ra, rb));
    end
    @(posedge clk); #1;

    do_md(2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg");
    do_md(2'b01, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, "multu");
    do_md(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    do_md(2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, "divu_by0");
    do_md(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf");
    do_md(2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_s_by0");

    for (int i = 0; i < 10; i++) begin
      mop = 2'($urandom); ra = $urandom; rb = $urandom;
      if (i == 3) rb = 32'd1;
      if (i == 4) ra = 32'h8000_0000;
      md_model(mop, ra, rb, eh, el);
      do_md(mop, ra, rb, eh, el, $sformatf("md_rand_%0d_op%0d", i, mop));
    end

    // Start and MT writes mid-operation must be ignored.
    a = 32'hFFFF_FFFD; b = 32'd5; md_op = 2'b00; md_start = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    md_start = 1'b1; md_op = 2'b11; a = 32'hDEAD; b = 32'd3; hi_we = 1'b1; lo_we = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    k = 5;
    wait_done(k);
    chk("busy_ign_latency", k, 33);
    chk("busy_ign_hi", hi, 32'hFFFF_FFFF);
    chk("busy_ign_lo", lo, 32'hFFFF_FFF1);
    @(posedge clk); #1;
    chk("busy_ign_idle", {31'd0, md_busy}, 0);

    a = 32'hABCD; hi_we = 1'b1;
    @(posedge clk); #1;
    hi_we = 1'b0;
    chk("mthi", hi, 32'hABCD);
    chk("mthi_lo_hold", lo, 32'hFFFF_FFF1);
    a = 32'h1234; lo_we = 1'b1;
    @(posedge clk); #1;
    lo_we = 1'b0;
    chk("mtlo", lo, 32'h1234);
    chk("mtlo_hi_hold", hi, 32'hABCD);

    // MT write alongside a start in IDLE: both take effect.
    a = 32'h5555; b = 32'd1; md_op = 2'b01; md_start = 1'b1; hi_we = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0; hi_we = 1'b0;
    chk("mt_start_hi", hi, 32'h5555);
    chk("mt_start_busy", {31'd0, md_busy}, 1);
    k = 0;
    wait_done(k);
    chk("mt_start_latency", k, 33);
    chk("mt_start_res_hi", hi, 0);
    chk("mt_start_res_lo", lo, 32'h5555);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of RUN.
    a = 32'd1000; b = 32'd3; md_op = 2'b11; md_start = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0;
    repeat (10) @(posedge clk);
    #2 clrn = 1'b0;
    #1;
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    chk("arst_busy", {31'd0, md_busy}, 0);
    chk("arst_done", {31'd0, md_done}, 0);
    @(posedge clk);
    #3 clrn = 1'b1;
    @(posedge clk); #1;
    chk("arst_stay_idle", {31'd0, md_busy}, 0);
    do_md(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, "divu_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
